// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD read and write paths.
// Holds the read FSM state encoding, RS pin meanings, bus widths and the
// position of the busy flag within a status byte.
package lcd_pkg;

  localparam int unsigned LCD_NIB_W  = 4;
  localparam int unsigned LCD_BYTE_W = 8;
  localparam int unsigned LCD_BF_BIT = 7;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_E_HI1,
    ST_E_LO1,
    ST_E_HI2,
    ST_E_LO2,
    ST_DONE
  } lcd_rd_state_e;

endpackage

// File: rtl/lcd_read_ctrl_if.sv
// Request/response handshake between a client and the LCD read controller.
//   master : client side   (drives req_valid, req_rs, req_wait_idle)
//   slave  : controller    (drives req_ready, resp_valid, resp_data, resp_timeout)
interface lcd_read_ctrl_if;
  import lcd_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rs;
  logic                  req_wait_idle;
  logic                  resp_valid;
  logic [LCD_BYTE_W-1:0] resp_data;
  logic                  resp_timeout;

  modport master (
    output req_valid, req_rs, req_wait_idle,
    input  req_ready, resp_valid, resp_data, resp_timeout
  );

  modport slave (
    input  req_valid, req_rs, req_wait_idle,
    output req_ready, resp_valid, resp_data, resp_timeout
  );
endinterface

// File: rtl/lcd_tick_gen.sv
// Bus-phase divider: tick_o is high for one clk out of every TICK_DIV.
// restart_i zeroes the count so the next tick lands a full TICK_DIV cycles
// later (tick_o is high while the count sits at TICK_DIV-1).
//   clk, rst  : clock, async active-low reset
//   restart_i : synchronous restart of the phase
//   tick_o    : one-clk phase-end strobe
module lcd_tick_gen #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..TICK_DIV-1; tick is registered one count early so it is
  // asserted exactly while the count is at its last value.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else begin
      if (cnt_q == CNT_W'(TICK_DIV - 1)) cnt_d = '0;
      else                               cnt_d = cnt_q + CNT_W'(1);
      tick_d = (cnt_q == CNT_W'(TICK_DIV - 2));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/lcd_read_ctrl.sv
// Read-side controller for a 4-bit HD44780 LCD bus. Performs a two-nibble
// read (status when RS=0, DDRAM/CGRAM data when RS=1) and optionally repeats
// status reads until the busy flag clears or BUSY_POLL_MAX retries elapse.
//   clk, rst   : clock, async active-low reset
//   rd         : request/response handshake (slave side)
//   bus_busy   : tells the pin arbiter to release lcd_db to the LCD
//   lcd_rs/rw/e: LCD control pins
//   lcd_db_in  : LCD D7..D4 while the bus is tristated
module lcd_read_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 50,
  parameter int unsigned BUSY_POLL_MAX = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_read_ctrl_if.slave       rd,
  output logic                 bus_busy,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  input  logic [LCD_NIB_W-1:0] lcd_db_in
);

  localparam int unsigned POLL_W = $clog2(BUSY_POLL_MAX + 1);

  lcd_rd_state_e         state_q, state_d;
  logic                  rs_q, rs_d;
  logic                  wait_q, wait_d;
  logic [LCD_BYTE_W-1:0] data_q, data_d;
  logic [POLL_W-1:0]     poll_q, poll_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [LCD_BYTE_W-1:0] resp_data_q, resp_data_d;
  logic                  resp_to_q, resp_to_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  lcd_rs_q, lcd_rs_d;
  logic                  lcd_rw_q, lcd_rw_d;
  logic                  lcd_e_q, lcd_e_d;
  logic                  accept_c;
  logic                  tick;

  assign accept_c = rd.req_valid & rdy_q;

  // Phase timer; restarting on accept makes SETUP a full phase.
  lcd_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (accept_c),
    .tick_o    (tick)
  );

  // Next-state, capture and registered-output decode.
  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    wait_d       = wait_q;
    data_d       = data_q;
    poll_d       = poll_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_to_d    = resp_to_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_SETUP;
          rs_d    = rd.req_rs;
          wait_d  = rd.req_wait_idle;
          poll_d  = '0;
        end
      end
      ST_SETUP: if (tick) state_d = ST_E_HI1;
      ST_E_HI1: begin
        if (tick) begin
          data_d[7:4] = lcd_db_in;
          state_d     = ST_E_LO1;
        end
      end
      ST_E_LO1: if (tick) state_d = ST_E_HI2;
      ST_E_HI2: begin
        if (tick) begin
          data_d[3:0] = lcd_db_in;
          state_d     = ST_E_LO2;
        end
      end
      ST_E_LO2: begin
        if (tick) begin
          // Only status reads in wait mode retry on BF=1.
          if (wait_q && (rs_q == LCD_RS_CMD) && data_q[LCD_BF_BIT]
              && (poll_q < POLL_W'(BUSY_POLL_MAX))) begin
            poll_d  = poll_q + POLL_W'(1);
            state_d = ST_SETUP;
          end else begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_data_d  = data_q;
            resp_to_d    = wait_q && (rs_q == LCD_RS_CMD) && data_q[LCD_BF_BIT];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pins follow the state being entered so they change on the state edge.
    rdy_d    = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
    lcd_rw_d = state_d inside {ST_SETUP, ST_E_HI1, ST_E_LO1, ST_E_HI2, ST_E_LO2};
    lcd_e_d  = state_d inside {ST_E_HI1, ST_E_HI2};
    lcd_rs_d = lcd_rw_d ? rs_d : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rs_q         <= 1'b0;
      wait_q       <= 1'b0;
      data_q       <= '0;
      poll_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_to_q    <= 1'b0;
      rdy_q        <= 1'b1;
      busy_q       <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_rw_q     <= 1'b0;
      lcd_e_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rs_q         <= rs_d;
      wait_q       <= wait_d;
      data_q       <= data_d;
      poll_q       <= poll_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_to_q    <= resp_to_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_rw_q     <= lcd_rw_d;
      lcd_e_q      <= lcd_e_d;
    end
  end

  assign rd.req_ready    = rdy_q;
  assign rd.resp_valid   = resp_valid_q;
  assign rd.resp_data    = resp_data_q;
  assign rd.resp_timeout = resp_to_q;
  assign bus_busy        = busy_q;
  assign lcd_rs          = lcd_rs_q;
  assign lcd_rw          = lcd_rw_q;
  assign lcd_e           = lcd_e_q;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Scoreboard bench for lcd_read_ctrl: two instances (deep and shallow poll
// limit) share one LCD nibble model; expected responses are queued at issue
// time and checked by a negedge monitor.
module tb_lcd_read_ctrl;
  import lcd_pkg::*;

  localparam int unsigned T     = 4;
  localparam int          LAT1  = 5 * T + 1;
  localparam int unsigned MAX_A = 8;
  localparam int unsigned MAX_B = 2;

  typedef struct {
    bit         sel;
    logic [7:0] data;
    logic       to;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] db  = 4'h0;
  logic       busy_a, rs_a, rw_a, e_a;
  logic       busy_b, rs_b, rw_b, e_b;
  logic       cur_rs = 1'b0;
  logic       e_prev = 1'b0;
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  exp_t       exp_q[$];
  logic [3:0] nib_q[$];
  int         acc_a[$];
  int         acc_b[$];
  int         hist_a[$];

  lcd_read_ctrl_if ifa ();
  lcd_read_ctrl_if ifb ();

  lcd_read_ctrl #(.TICK_DIV(T), .BUSY_POLL_MAX(MAX_A)) dut_a (
    .clk(clk), .rst(rst), .rd(ifa), .bus_busy(busy_a),
    .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_e(e_a), .lcd_db_in(db)
  );

  lcd_read_ctrl #(.TICK_DIV(T), .BUSY_POLL_MAX(MAX_B)) dut_b (
    .clk(clk), .rst(rst), .rd(ifb), .bus_busy(busy_b),
    .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_e(e_b), .lcd_db_in(db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_resp(bit sel, logic [7:0] d, logic to);
    exp_t e;
    int   a;
    if (exp_q.size() == 0) begin
      chk("unexpected_resp", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("resp_port", int'(sel), int'(e.sel));
    chk("resp_data", int'(d), int'(e.data));
    chk("resp_timeout", int'(to), int'(e.to));
    if (sel) a = (acc_b.size() != 0) ? acc_b.pop_front() : -1000;
    else     a = (acc_a.size() != 0) ? acc_a.pop_front() : -1000;
    chk("resp_latency", cyc + 1 - a, e.lat);
  endtask

  // Accept tracking and response scoreboard; edge index = cyc+1 at negedge.
  always @(negedge clk) begin
    if (rst) begin
      if (ifa.req_valid && ifa.req_ready) begin
        acc_a.push_back(cyc + 1);
        hist_a.push_back(cyc + 1);
      end
      if (ifb.req_valid && ifb.req_ready) acc_b.push_back(cyc + 1);
      if (ifa.resp_valid) check_resp(1'b0, ifa.resp_data, ifa.resp_timeout);
      if (ifb.resp_valid) check_resp(1'b1, ifb.resp_data, ifb.resp_timeout);
    end
  end

  // LCD model: presents the next nibble after each rising E.
  always @(negedge clk) begin
    if ((e_a | e_b) && !e_prev) begin
      chk("rw_at_e_rise", int'(rw_a | rw_b), 1);
      chk("rs_at_e_rise", int'(rs_a | rs_b), int'(cur_rs));
      db <= (nib_q.size() != 0) ? nib_q.pop_front() : 4'h0;
    end
    e_prev <= e_a | e_b;
  end

  task automatic push_byte(logic [7:0] b);
    nib_q.push_back(b[7:4]);
    nib_q.push_back(b[3:0]);
  endtask

  task automatic expect_resp(bit sel, logic [7:0] d, logic to, int lat);
    exp_t e;
    e.sel = sel; e.data = d; e.to = to; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic issue(bit sel, logic rs, logic wt);
    int n = 0;
    @(posedge clk); #1;
    cur_rs = rs;
    if (sel) begin
      ifb.req_valid = 1'b1; ifb.req_rs = rs; ifb.req_wait_idle = wt;
    end else begin
      ifa.req_valid = 1'b1; ifa.req_rs = rs; ifa.req_wait_idle = wt;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? ifb.req_ready : ifa.req_ready) && n < 500);
    if (n >= 500) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    ifb.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("resp_missing", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    ifa.req_valid = 1'b0; ifa.req_rs = 1'b0; ifa.req_wait_idle = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_rs = 1'b0; ifb.req_wait_idle = 1'b0;

    // Reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_lcd_rs", int'(rs_a), 0);
    chk("rst_lcd_rw", int'(rw_a), 0);
    chk("rst_lcd_e", int'(e_a), 0);
    chk("rst_bus_busy", int'(busy_a), 0);
    chk("rst_resp_valid", int'(ifa.resp_valid), 0);
    chk("rst_resp_data", int'(ifa.resp_data), 0);
    chk("rst_resp_timeout", int'(ifa.resp_timeout), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(ifa.req_ready), 1);

    // Data read, high nibble first
    push_byte(8'hA5);
    expect_resp(1'b0, 8'hA5, 1'b0, LAT1);
    issue(1'b0, 1'b1, 1'b0);
    wait_drain();

    // Status read without polling, BF=1 returned as-is
    push_byte(8'h83);
    expect_resp(1'b0, 8'h83, 1'b0, LAT1);
    issue(1'b0, 1'b0, 1'b0);
    wait_drain();

    // wait_idle ignored on a data read even with bit 7 set
    push_byte(8'hF0);
    expect_resp(1'b0, 8'hF0, 1'b0, LAT1);
    issue(1'b0, 1'b1, 1'b1);
    wait_drain();

    // Poll: three busy reads then idle
    push_byte(8'h81); push_byte(8'h92); push_byte(8'h83); push_byte(8'h04);
    expect_resp(1'b0, 8'h04, 1'b0, 4 * 5 * T + 1);
    issue(1'b0, 1'b0, 1'b1);
    wait_drain();

    // Poll limit 2: BF stuck high gives timeout after three reads
    push_byte(8'h80); push_byte(8'h80); push_byte(8'h80);
    expect_resp(1'b1, 8'h80, 1'b1, 3 * 5 * T + 1);
    issue(1'b1, 1'b0, 1'b1);
    wait_drain();
    chk("idle_lcd_rw_b", int'(rw_b), 0);
    chk("idle_ready_b", int'(ifb.req_ready), 1);
    chk("idle_busy_b", int'(busy_b), 0);

    // Backpressure: valid held across a whole transaction
    push_byte(8'h12); push_byte(8'h34);
    expect_resp(1'b0, 8'h12, 1'b0, LAT1);
    expect_resp(1'b0, 8'h34, 1'b0, LAT1);
    hist_a.delete();
    @(posedge clk); #1;
    cur_rs = 1'b1;
    ifa.req_rs = 1'b1; ifa.req_wait_idle = 1'b0; ifa.req_valid = 1'b1;
    n = 0;
    while (hist_a.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    ifa.req_valid = 1'b0;
    wait_drain();
    chk("bp_accepts", hist_a.size(), 2);
    if (hist_a.size() >= 2) chk("bp_accept_gap", hist_a[1] - hist_a[0], LAT1 + 1);

    // Reset during E_HI2 aborts without a response
    push_byte(8'h56);
    issue(1'b0, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #2;
    chk("e_high_before_abort", int'(e_a), 1);
    rst = 1'b0;
    #1;
    chk("abort_lcd_e", int'(e_a), 0);
    chk("abort_lcd_rw", int'(rw_a), 0);
    chk("abort_bus_busy", int'(busy_a), 0);
    chk("abort_resp_valid", int'(ifa.resp_valid), 0);
    repeat (2) @(negedge clk);
    nib_q.delete();
    acc_a.delete();
    #1 rst = 1'b1;
    repeat (6 * T) @(negedge clk);

    // Normal read after the abort
    push_byte(8'hC3);
    expect_resp(1'b0, 8'hC3, 1'b0, LAT1);
    issue(1'b0, 1'b1, 1'b0);
    wait_drain();
    chk("nibbles_consumed", nib_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
